// File: rtl/tl_ram.sv
// TileLink-UL single-beat slave RAM. It keeps one buffered channel-D response and can
// accept a new request in the same cycle the current response drains, so it sustains 1 req/cycle.
module tl_ram_lane #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [7:0]       i_wdata,
  output logic [7:0]       o_rdata
);
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q;

  // The memory has no reset, so its contents survive rst.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_q <= r_mem[i_idx];
  end

  assign o_rdata = r_q;
endmodule

module tl_ram #(
  parameter int                DATA_W = 64,
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 4096,
  parameter int                SRC_W  = 4,
  parameter logic [ADDR_W-1:0] BASE   = 'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [SRC_W-1:0]    a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_mask,
  input  logic [DATA_W-1:0]   a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [SRC_W-1:0]    d_source,
  output logic [DATA_W-1:0]   d_data,
  output logic                d_error
);
  localparam int BYTES = DATA_W / 8;
  localparam int LOG   = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  logic                     r_d_valid;
  logic [2:0]               r_d_opcode;
  logic [SRC_W-1:0]         r_d_source;
  logic                     r_d_error;
  logic                     r_rd_sel;

  logic                     w_accept;
  logic [ADDR_W-1:0]        w_off;
  logic [ADDR_W-1:0]        w_word;
  logic                     w_in_range;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_is_get;
  logic                     w_is_put;
  logic                     w_wr_en;
  logic                     w_rd_en;
  logic [BYTES-1:0]         w_be;
  logic [BYTES-1:0][7:0]    w_lane_q;

  assign a_ready  = ~r_d_valid | d_ready;
  assign w_accept = a_valid & a_ready;

  // Subtraction wraps in ADDR_W bits; addresses below BASE are rejected by the compare.
  assign w_off      = a_address - BASE;
  assign w_word     = w_off >> LOG;
  assign w_in_range = (a_address >= BASE) && (w_word < ADDR_W'(DEPTH));
  assign w_idx      = w_word[IDX_W-1:0];

  assign w_is_get = (a_opcode == OP_GET);
  assign w_is_put = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
  assign w_be     = (a_opcode == OP_PUT_FULL) ? '1 : a_mask;
  assign w_wr_en  = w_accept & w_in_range & w_is_put & ~rst;
  assign w_rd_en  = w_accept & w_in_range & w_is_get;

  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    tl_ram_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk     (clk),
      .i_we    (w_wr_en & w_be[b]),
      .i_re    (w_rd_en),
      .i_idx   (w_idx),
      .i_wdata (a_data[b*8 +: 8]),
      .o_rdata (w_lane_q[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_valid  <= 1'b0;
      r_d_opcode <= 3'd0;
      r_d_source <= '0;
      r_d_error  <= 1'b0;
      r_rd_sel   <= 1'b0;
    end else if (w_accept) begin
      r_d_valid  <= 1'b1;
      r_d_opcode <= {2'b00, w_is_get};
      r_d_source <= a_source;
      r_d_error  <= ~(w_is_get | w_is_put) | ~w_in_range;
      r_rd_sel   <= w_is_get & w_in_range;
    end else if (d_ready) begin
      r_d_valid  <= 1'b0;
    end
  end

  // Only a successful Get exposes lane data; everything else returns zero.
  assign d_valid  = r_d_valid;
  assign d_opcode = r_d_opcode;
  assign d_source = r_d_source;
  assign d_error  = r_d_error;
  assign d_data   = r_rd_sel ? w_lane_q : '0;
endmodule

// File: tb/tb_tl_ram.sv
// Randomised and directed checks of tl_ram against a word-level behavioural memory model.
module tb_tl_ram;
  localparam int          DEPTH  = 4096;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam longint      BASE_L = 64'h8000_0000;

  logic        clk, rst;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [3:0]  d_source;
  logic [63:0] d_data;
  logic        d_error;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  src;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  logic [63:0] mdl [int];

  tl_ram #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH), .SRC_W(4), .BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
    .d_data(d_data), .d_error(d_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level model: apply one accepted request and return the expected response.
  function automatic rsp_t model(input logic [2:0] op, input logic [3:0] src,
                                 input logic [31:0] addr, input logic [7:0] mask,
                                 input logic [63:0] data);
    rsp_t r;
    longint a;
    int idx;
    bit inr;
    logic [63:0] w;
    a = {32'h0, addr};
    inr = (a >= BASE_L) && ((a - BASE_L) / 8 < DEPTH);
    idx = inr ? int'((a - BASE_L) / 8) : 0;
    r.op = 3'd0; r.src = src; r.data = 64'h0; r.err = 1'b0;
    if (op == 3'd4) begin
      r.op = 3'd1;
      if (inr) r.data = mdl.exists(idx) ? mdl[idx] : 64'h0;
      else r.err = 1'b1;
    end else if (op == 3'd0 || op == 3'd1) begin
      if (inr) begin
        w = mdl.exists(idx) ? mdl[idx] : 64'h0;
        for (int b = 0; b < 8; b++)
          if (op == 3'd0 || mask[b]) w[b*8 +: 8] = data[b*8 +: 8];
        mdl[idx] = w;
      end else r.err = 1'b1;
    end else begin
      r.err = 1'b1;
    end
    return r;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [3:0] src, input logic [31:0] addr,
                       input logic [7:0] mask, input logic [63:0] data);
    a_valid = 1'b1; a_opcode = op; a_source = src;
    a_address = addr; a_mask = mask; a_data = data;
  endtask

  // One request with d_ready high; returns the model's expected response, no checking.
  task automatic xact(input logic [2:0] op, input logic [3:0] src, input logic [31:0] addr,
                      input logic [7:0] mask, input logic [63:0] data, output rsp_t e);
    d_ready = 1'b1;
    e = model(op, src, addr, mask, data);
    drive(op, src, addr, mask, data);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; a_valid = 1'b0; d_ready = 1'b0;
    a_opcode = 3'd0; a_source = 4'd0; a_address = 32'h0; a_mask = 8'h0; a_data = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({d_valid, d_opcode, d_source, d_error} !== 9'h0) begin
      failures++;
      $display("FAIL reset_ctrl got v=%0b op=%0d src=%0d err=%0b want all 0",
               d_valid, d_opcode, d_source, d_error);
    end
    checks++;
    if (d_data !== 64'h0) begin
      failures++; $display("FAIL reset_data got %h want 0", d_data);
    end
    checks++;
    if (a_ready !== 1'b1) begin
      failures++; $display("FAIL reset_a_ready got %b want 1", a_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_put_get;
    rsp_t e;
    xact(3'd0, 4'd3, BASE + 32'h10, 8'hFF, 64'h1122334455667788, e);
    checks++;
    if ({d_valid, d_opcode, d_source, d_data, d_error} !== {1'b1, 3'd0, 4'd3, 64'h0, 1'b0}) begin
      failures++;
      $display("FAIL put_full_ack got v=%0b op=%0d src=%0d d=%h err=%0b want v=1 op=0 src=3 d=0 err=0",
               d_valid, d_opcode, d_source, d_data, d_error);
    end
    xact(3'd4, 4'd5, BASE + 32'h10, 8'h00, 64'h0, e);
    checks++;
    if ({d_valid, d_opcode, d_source, d_data, d_error} !==
        {1'b1, 3'd1, 4'd5, 64'h1122334455667788, 1'b0}) begin
      failures++;
      $display("FAIL get_after_put got v=%0b op=%0d src=%0d d=%h err=%0b want v=1 op=1 src=5 d=1122334455667788 err=0",
               d_valid, d_opcode, d_source, d_data, d_error);
    end
    xact(3'd1, 4'd6, BASE + 32'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, e);
    checks++;
    if ({d_valid, d_opcode, d_source, d_error} !== {1'b1, 3'd0, 4'd6, 1'b0}) begin
      failures++;
      $display("FAIL put_partial_ack got v=%0b op=%0d src=%0d err=%0b want v=1 op=0 src=6 err=0",
               d_valid, d_opcode, d_source, d_error);
    end
    xact(3'd4, 4'd7, BASE + 32'h10, 8'h00, 64'h0, e);
    checks++;
    if (d_data !== 64'h11223344BBBBBBBB) begin
      failures++; $display("FAIL get_after_partial got %h want 11223344bbbbbbbb", d_data);
    end
    xact(3'd1, 4'd8, BASE + 32'h10, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, e);
    checks++;
    if ({d_valid, d_opcode, d_error} !== {1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL mask0_ack got v=%0b op=%0d err=%0b want v=1 op=0 err=0", d_valid, d_opcode, d_error);
    end
    xact(3'd4, 4'd9, BASE + 32'h10, 8'h00, 64'h0, e);
    checks++;
    if (d_data !== 64'h11223344BBBBBBBB) begin
      failures++; $display("FAIL mask0_nochange got %h want 11223344bbbbbbbb", d_data);
    end
  endtask

  task automatic test_back_to_back;
    rsp_t e, ea, eb;
    d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = model(3'd0, 4'(i), BASE + 32'h100 + 32'(i * 8), 8'hFF, 64'hC0DE_0000_0000_0000 + 64'(i));
      drive(3'd0, 4'(i), BASE + 32'h100 + 32'(i * 8), 8'hFF, 64'hC0DE_0000_0000_0000 + 64'(i));
      @(posedge clk); #1;
      checks++;
      if ({d_valid, d_source, a_ready} !== {1'b1, e.src, 1'b1}) begin
        failures++;
        $display("FAIL b2b_put[%0d] got v=%0b src=%0d rdy=%0b want v=1 src=%0d rdy=1",
                 i, d_valid, d_source, a_ready, e.src);
      end
    end
    for (int i = 0; i < 4; i++) begin
      e = model(3'd4, 4'(i + 4), BASE + 32'h100 + 32'(i * 8), 8'h00, 64'h0);
      drive(3'd4, 4'(i + 4), BASE + 32'h100 + 32'(i * 8), 8'h00, 64'h0);
      @(posedge clk); #1;
      checks++;
      if ({d_valid, d_opcode, d_source, d_data} !== {1'b1, e.op, e.src, e.data}) begin
        failures++;
        $display("FAIL b2b_get[%0d] got v=%0b op=%0d src=%0d d=%h want v=1 op=%0d src=%0d d=%h",
                 i, d_valid, d_opcode, d_source, d_data, e.op, e.src, e.data);
      end
    end
    ea = model(3'd4, 4'd9, BASE + 32'h100, 8'h00, 64'h0);
    drive(3'd4, 4'd9, BASE + 32'h100, 8'h00, 64'h0);
    @(posedge clk); #1;
    d_ready = 1'b0;
    drive(3'd4, 4'd10, BASE + 32'h108, 8'h00, 64'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({a_ready, d_valid, d_opcode, d_source, d_data, d_error} !==
          {1'b0, 1'b1, ea.op, ea.src, ea.data, ea.err}) begin
        failures++;
        $display("FAIL stall_hold[%0d] got rdy=%0b v=%0b src=%0d d=%h want rdy=0 v=1 src=%0d d=%h",
                 c, a_ready, d_valid, d_source, d_data, ea.src, ea.data);
      end
      @(posedge clk); #1;
    end
    d_ready = 1'b1;
    eb = model(3'd4, 4'd10, BASE + 32'h108, 8'h00, 64'h0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++;
    if ({d_valid, d_source, d_data} !== {1'b1, eb.src, eb.data}) begin
      failures++;
      $display("FAIL stall_resume got v=%0b src=%0d d=%h want v=1 src=%0d d=%h",
               d_valid, d_source, d_data, eb.src, eb.data);
    end
    @(posedge clk); #1;
    checks++;
    if (d_valid !== 1'b0) begin
      failures++; $display("FAIL drain_idle got v=%0b want 0", d_valid);
    end
  endtask

  task automatic test_errors;
    rsp_t e;
    logic [31:0] bad [3];
    bad[0] = BASE - 32'd8; bad[1] = BASE + 32'(DEPTH * 8); bad[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      xact(3'd4, 4'(i + 1), bad[i], 8'h00, 64'h0, e);
      checks++;
      if ({d_valid, d_opcode, d_data, d_error} !== {1'b1, 3'd1, 64'h0, 1'b1}) begin
        failures++;
        $display("FAIL oor_get[%0d] got v=%0b op=%0d d=%h err=%0b want v=1 op=1 d=0 err=1",
                 i, d_valid, d_opcode, d_data, d_error);
      end
    end
    xact(3'd0, 4'd4, BASE + 32'(DEPTH * 8), 8'hFF, 64'h1, e);
    checks++;
    if ({d_valid, d_opcode, d_error} !== {1'b1, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL oor_put got v=%0b op=%0d err=%0b want v=1 op=0 err=1", d_valid, d_opcode, d_error);
    end
    xact(3'd2, 4'd2, BASE + 32'h10, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, e);
    checks++;
    if ({d_valid, d_opcode, d_source, d_data, d_error} !== {1'b1, 3'd0, 4'd2, 64'h0, 1'b1}) begin
      failures++;
      $display("FAIL bad_opcode got v=%0b op=%0d src=%0d d=%h err=%0b want v=1 op=0 src=2 d=0 err=1",
               d_valid, d_opcode, d_source, d_data, d_error);
    end
    xact(3'd4, 4'd11, BASE + 32'h10, 8'h00, 64'h0, e);
    checks++;
    if ({d_data, d_error} !== {64'h11223344BBBBBBBB, 1'b0}) begin
      failures++;
      $display("FAIL get_after_errors got d=%h err=%0b want d=11223344bbbbbbbb err=0", d_data, d_error);
    end
  endtask

  task automatic test_reset_mid;
    rsp_t e;
    logic [63:0] v;
    v = {$urandom, $urandom};
    xact(3'd0, 4'd1, BASE + 32'h200, 8'hFF, v, e);
    d_ready = 1'b0;
    drive(3'd4, 4'd7, BASE + 32'h200, 8'h00, 64'h0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({d_valid, d_data} !== {1'b0, 64'h0}) begin
      failures++; $display("FAIL async_reset got v=%0b d=%h want v=0 d=0", d_valid, d_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    xact(3'd4, 4'd12, BASE + 32'h200, 8'h00, 64'h0, e);
    checks++;
    if ({d_valid, d_data, d_error} !== {1'b1, v, 1'b0}) begin
      failures++;
      $display("FAIL mem_survives_reset got v=%0b d=%h err=%0b want v=1 d=%h err=0",
               d_valid, d_data, d_error, v);
    end
  endtask

  task automatic test_last_word;
    rsp_t e;
    logic [63:0] v;
    v = {$urandom, $urandom};
    xact(3'd0, 4'd13, BASE + 32'((DEPTH - 1) * 8), 8'hFF, v, e);
    xact(3'd4, 4'd14, BASE + 32'((DEPTH - 1) * 8) + 32'd5, 8'h00, 64'h0, e);
    checks++;
    if ({d_valid, d_opcode, d_data, d_error} !== {1'b1, 3'd1, v, 1'b0}) begin
      failures++;
      $display("FAIL last_word got v=%0b op=%0d d=%h err=%0b want v=1 op=1 d=%h err=0",
               d_valid, d_opcode, d_data, d_error, v);
    end
  endtask

  task automatic test_random;
    rsp_t e, q[$];
    logic [2:0]  op;
    logic [31:0] addr;
    int sel, accepted, waited;
    for (int i = 0; i < 16; i++)
      xact(3'd0, 4'd0, BASE + 32'(i * 8), 8'hFF, {$urandom, $urandom}, e);
    @(posedge clk); #1;
    accepted = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!a_valid || accepted != 0) begin
        a_valid = 1'b0;
        if ($urandom_range(9) < 7) begin
          sel = $urandom_range(9);
          addr = BASE + 32'($urandom_range(15) * 8) + 32'($urandom_range(7));
          if (sel < 4) op = 3'd4;
          else if (sel < 6) op = 3'd0;
          else if (sel < 8) op = 3'd1;
          else if (sel == 8) begin
            op = ($urandom_range(1) != 0) ? 3'd4 : 3'd0;
            addr = ($urandom_range(1) != 0) ? BASE - 32'(8 * (1 + $urandom_range(99)))
                                            : BASE + 32'(DEPTH * 8) + 32'($urandom_range(999) * 8);
          end else begin
            case ($urandom_range(4))
              0: op = 3'd2;
              1: op = 3'd3;
              2: op = 3'd5;
              3: op = 3'd6;
              default: op = 3'd7;
            endcase
          end
          drive(op, 4'($urandom), addr, 8'($urandom), {$urandom, $urandom});
        end
      end
      d_ready = ($urandom_range(3) != 0);
      #1;
      checks++;
      if (q.size() != int'(d_valid)) begin
        failures++;
        $display("FAIL rnd_outstanding cyc=%0d got d_valid=%0b want %0d", cyc, d_valid, q.size());
      end
      if (d_valid && d_ready && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({d_opcode, d_source, d_data, d_error} !== {e.op, e.src, e.data, e.err}) begin
          failures++;
          $display("FAIL rnd_resp cyc=%0d got op=%0d src=%0d d=%h err=%0b want op=%0d src=%0d d=%h err=%0b",
                   cyc, d_opcode, d_source, d_data, d_error, e.op, e.src, e.data, e.err);
        end
      end
      accepted = (a_valid && a_ready) ? 1 : 0;
      if (accepted != 0) q.push_back(model(a_opcode, a_source, a_address, a_mask, a_data));
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    d_ready = 1'b1;
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      #1;
      if (d_valid) begin
        e = q.pop_front();
        checks++;
        if ({d_opcode, d_source, d_data, d_error} !== {e.op, e.src, e.data, e.err}) begin
          failures++;
          $display("FAIL rnd_drain got op=%0d src=%0d d=%h err=%0b want op=%0d src=%0d d=%h err=%0b",
                   d_opcode, d_source, d_data, d_error, e.op, e.src, e.data, e.err);
        end
      end
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++; $display("FAIL rnd_timeout got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_last_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
